// File: rtl/dac_stream_tx.sv
// J2 DAC transmit path: buffers fabric samples in a small FIFO and plays them out
// on the DAC data bus with a divided sample clock. The DAC latches on the rising edge.
module dac_stream_tx #(
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 8,
   parameter int                HALF_DIV   = 2,
   parameter logic [DATA_W-1:0] IDLE_CODE  = DATA_W'('h80)
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_en,
   input  logic [DATA_W-1:0]               i_sample,
   input  logic                            i_valid,
   output logic                            o_ready,
   output logic                            o_J2_DA_CLK,
   output logic [DATA_W-1:0]               o_J2_DA_PORT,
   output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
   output logic                            o_underrun,
   input  logic                            i_clr_underrun
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 da_clk, da_clk_nxt;
   logic [DATA_W-1:0]    da_port, da_port_nxt;
   logic [DATA_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [LVL_W-1:0]     level;
   logic                 underrun;
   logic                 push, pop, load, uflow, empty;

   assign empty        = (level == '0);
   assign o_ready      = (level != LVL_W'(FIFO_DEPTH));
   assign push         = i_valid && o_ready;
   assign o_J2_DA_CLK  = da_clk;
   assign o_J2_DA_PORT = da_port;
   assign o_fifo_level = level;
   assign o_underrun   = underrun;

   // Sequencer: a load tick happens on entry to RUN and on every falling edge of the DAC clock.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      da_clk_nxt  = da_clk;
      da_port_nxt = da_port;
      load        = 1'b0;
      pop         = 1'b0;
      uflow       = 1'b0;
      case (state)
         IDLE: begin
            if (i_en) begin
               state_nxt  = RUN;
               cnt_nxt    = '0;
               da_clk_nxt = 1'b0;
               load       = 1'b1;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(HALF_DIV - 1)) begin
               cnt_nxt    = '0;
               da_clk_nxt = !da_clk;
               // Enable is only honoured at period boundaries so the DAC never sees a runt pulse.
               if (da_clk) begin
                  if (i_en) begin
                     load = 1'b1;
                  end else begin
                     state_nxt   = IDLE;
                     da_port_nxt = IDLE_CODE;
                  end
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) begin
         if (!empty) begin
            pop         = 1'b1;
            da_port_nxt = mem[rd_ptr];
         end else begin
            uflow = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         da_clk   <= 1'b0;
         da_port  <= IDLE_CODE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         underrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         da_clk  <= da_clk_nxt;
         da_port <= da_port_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (uflow)               underrun <= 1'b1;
         else if (i_clr_underrun) underrun <= 1'b0;
      end
   end

   // Storage carries no reset; occupancy is tracked by the pointers and level alone.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_sample;
   end

endmodule

// File: tb/tb_dac_stream_tx.sv
// Bench for dac_stream_tx: accepted samples go into a scoreboard queue and are
// compared against the DAC port at every rising edge of the DAC clock.
module tb_dac_stream_tx;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_en = 1'b0;
   logic [7:0] i_sample = 8'h00;
   logic       i_valid = 1'b0;
   logic       i_clr_underrun = 1'b0;
   logic       o_ready;
   logic       o_J2_DA_CLK;
   logic [7:0] o_J2_DA_PORT;
   logic [3:0] o_fifo_level;
   logic       o_underrun;

   dac_stream_tx #(
      .DATA_W(8), .FIFO_DEPTH(8), .HALF_DIV(2), .IDLE_CODE(8'h80)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sample(i_sample),
      .i_valid(i_valid), .o_ready(o_ready), .o_J2_DA_CLK(o_J2_DA_CLK),
      .o_J2_DA_PORT(o_J2_DA_PORT), .o_fifo_level(o_fifo_level),
      .o_underrun(o_underrun), .i_clr_underrun(i_clr_underrun)
   );

   always #20 i_clk = ~i_clk;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] hold_val = 8'h80;
   logic [7:0] rise_val = 8'h80;
   logic [7:0] ph1 = 8'h80, ph2 = 8'h80;
   logic       prev_clk = 1'b0;
   bit         mon_en = 1'b0;
   logic [7:0] next_val = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver steps land 1 time unit after the falling edge; the monitor runs on the edge itself.
   task automatic step();
      @(negedge i_clk);
      #1;
   endtask

   // Monitor: check data at every DAC rising edge plus stability around it.
   always @(negedge i_clk) begin
      logic [7:0] e;
      if (mon_en) begin
         if (o_J2_DA_CLK && !prev_clk) begin
            chk("stable_before_rise_1", o_J2_DA_PORT, ph1);
            chk("stable_before_rise_2", o_J2_DA_PORT, ph2);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               hold_val = e;
            end else begin
               e = hold_val;
            end
            chk("da_data", o_J2_DA_PORT, e);
            rise_val = o_J2_DA_PORT;
         end
         if (!o_J2_DA_CLK && prev_clk)
            chk("stable_after_rise", ph1, rise_val);
      end
      ph2 = ph1;
      ph1 = o_J2_DA_PORT;
      prev_clk = o_J2_DA_CLK;
   end

   // Offer n samples with i_valid held high; each accepted sample is queued as expected output.
   task automatic stream(input int n, input bit chk_gap);
      int sent = 0, cyc = 0, last = 0, nacc = 0;
      while (sent < n && cyc < 2000) begin
         step();
         i_valid  = 1'b1;
         i_sample = next_val;
         if (o_ready) begin
            exp_q.push_back(next_val);
            next_val = next_val + 8'd1;
            sent++;
            nacc++;
            if (chk_gap && nacc >= 2) chk("ready_gap", cyc - last, 4);
            last = cyc;
         end
         cyc++;
      end
      if (sent != n) chk("stream_timeout", sent, n);
      step();
      i_valid = 1'b0;
   endtask

   // second=0: first high cycle of the DAC clock; second=1: last high cycle before the fall.
   task automatic wait_high(input bit second);
      logic dprev;
      bit   found = 1'b0;
      dprev = o_J2_DA_CLK;
      for (int k = 0; k < 50 && !found; k++) begin
         step();
         if (o_J2_DA_CLK && (second ? dprev : !dprev)) found = 1'b1;
         dprev = o_J2_DA_CLK;
      end
      if (!found) chk("wait_high_timeout", 0, 1);
   endtask

   initial begin
      // Reset values
      repeat (3) step();
      i_rst_n = 1'b1;
      step();
      chk("rst_port", o_J2_DA_PORT, 8'h80);
      chk("rst_clk", o_J2_DA_CLK, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_level", o_fifo_level, 0);
      chk("rst_underrun", o_underrun, 0);
      mon_en = 1'b1;

      // Four samples then run; fifth load tick underruns and holds CF
      next_val = 8'hCC;
      stream(4, 1'b0);
      chk("t1_level", o_fifo_level, 4);
      i_en = 1'b1;
      repeat (16) step();
      chk("t1_underrun_before", o_underrun, 0);
      chk("t1_port_cf", o_J2_DA_PORT, 8'hCF);
      step();
      chk("t1_underrun_after", o_underrun, 1);
      chk("t1_port_hold", o_J2_DA_PORT, 8'hCF);
      chk("t1_clk_low", o_J2_DA_CLK, 0);

      // Clear on an underrun load tick loses to the set; clear alone wins
      wait_high(1'b1);
      i_clr_underrun = 1'b1;
      step();
      i_clr_underrun = 1'b0;
      chk("clr_vs_set", o_underrun, 1);
      i_clr_underrun = 1'b1;
      step();
      i_clr_underrun = 1'b0;
      chk("clr_alone", o_underrun, 0);

      // Fill while idle: 8 accepted, ninth held off
      i_en = 1'b0;
      repeat (8) step();
      chk("idle_clk", o_J2_DA_CLK, 0);
      chk("idle_port", o_J2_DA_PORT, 8'h80);
      next_val = 8'h10;
      stream(8, 1'b0);
      chk("full_level", o_fifo_level, 8);
      chk("full_ready", o_ready, 0);
      i_valid  = 1'b1;
      i_sample = next_val;
      repeat (3) step();
      chk("held_off_level", o_fifo_level, 8);

      // Continuous stream across pointer wrap, then drain
      i_en = 1'b1;
      stream(24, 1'b1);
      repeat (40) step();
      chk("drain_level", o_fifo_level, 0);
      chk("drain_queue", exp_q.size(), 0);

      // Drop enable in the high phase, then resume
      i_en = 1'b0;
      repeat (8) step();
      next_val = 8'hA0;
      stream(4, 1'b0);
      i_en = 1'b1;
      wait_high(1'b0);
      i_en = 1'b0;
      repeat (4) step();
      chk("stop_clk", o_J2_DA_CLK, 0);
      chk("stop_port", o_J2_DA_PORT, 8'h80);
      chk("stop_level", o_fifo_level, 3);
      repeat (4) step();
      chk("stop_level_idle", o_fifo_level, 3);
      i_en = 1'b1;
      repeat (20) step();
      chk("resume_queue", exp_q.size(), 0);

      // Reset asserted mid-run
      i_en = 1'b0;
      repeat (8) step();
      next_val = 8'h55;
      stream(3, 1'b0);
      i_en = 1'b1;
      repeat (5) step();
      mon_en  = 1'b0;
      i_rst_n = 1'b0;
      step();
      chk("mid_rst_port", o_J2_DA_PORT, 8'h80);
      chk("mid_rst_clk", o_J2_DA_CLK, 0);
      chk("mid_rst_ready", o_ready, 1);
      chk("mid_rst_level", o_fifo_level, 0);
      chk("mid_rst_underrun", o_underrun, 0);
      i_rst_n = 1'b1;
      i_en    = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
